// File: rtl/sumador_completo_if.sv
// sumador_completo_if
// Groups the adder's operand, mode and result signals into one bundle.
// Ports (as seen by the adder, slave modport):
//   a, b        in   addend bits
//   cin         in   external carry-in, used when serial_en = 0
//   serial_en   in   1 selects the internal carry register as carry-in
//   sum, cout   out  combinational sum / carry-out
//   sum_q       out  registered sum
//   cout_q      out  registered carry-out
//   carry_state out  internal serial carry register
// The master modport is the driving side (testbench or enclosing datapath).
interface sumador_completo_if;
  logic a;
  logic b;
  logic cin;
  logic serial_en;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic carry_state;

  modport master (
    output a, b, cin, serial_en,
    input  sum, cout, sum_q, cout_q, carry_state
  );

  modport slave (
    input  a, b, cin, serial_en,
    output sum, cout, sum_q, cout_q, carry_state
  );
endinterface

// File: rtl/sumador_completo.sv
// sumador_completo
// One-bit full adder with combinational outputs, registered copies of those
// outputs and a bit-serial mode in which the registered carry is fed back as
// the carry-in, so multi-bit operands can be added one bit per clock, LSB
// first.
// Ports:
//   clk    in   single clock, all state updates on the rising edge
//   reset  in   asynchronous, active-high; clears registers only
//   bus    slave side of sumador_completo_if (operands, mode, results)
module sumador_completo (
  input  logic                     clk,
  input  logic                     reset,
  sumador_completo_if.slave        bus
);

  logic ci;
  logic sum_c;
  logic cout_c;
  logic sum_r;
  logic cout_r;
  logic carry_r;

  // Effective carry-in comes from the serial carry register in bit-serial
  // mode, otherwise from the external pin. Outputs stay purely combinational
  // so they remain valid even while reset holds the registers cleared.
  always_comb begin
    ci     = bus.serial_en ? carry_r : bus.cin;
    sum_c  = bus.a ^ bus.b ^ ci;
    cout_c = (bus.a & bus.b) | (bus.a & ci) | (bus.b & ci);
  end

  // Registered copies plus the serial carry. Leaving serial mode clears the
  // carry at the next edge, so one cycle with serial_en = 0 is enough to
  // start a fresh serial add without pulsing reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r   <= 1'b0;
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      sum_r   <= sum_c;
      cout_r  <= cout_c;
      carry_r <= bus.serial_en ? cout_c : 1'b0;
    end
  end

  assign bus.sum         = sum_c;
  assign bus.cout        = cout_c;
  assign bus.sum_q       = sum_r;
  assign bus.cout_q      = cout_r;
  assign bus.carry_state = carry_r;

endmodule

// File: tb/tb_sumador_completo.sv
// tb_sumador_completo
// Self-checking bench for sumador_completo: a truth-table pass, hand-written
// sequences for the registered and serial corner cases, random single-cycle
// stimulus against an arithmetic reference, and random multi-bit serial adds
// checked against plain integer addition.
module tb_sumador_completo;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sumador_completo_if bus ();

  sumador_completo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 time-unit clock; inputs change on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] expected;
  } vec_t;

  vec_t vecs [8];

  // Reference state for the random single-cycle phase
  int m_carry;
  int m_sum_q;
  int m_cout_q;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic b, input logic cin, input logic serial_en);
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.serial_en = serial_en;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_output("reset_carry_state", int'(bus.carry_state), 0);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] res;
    logic       ra;
    logic       rb;
    logic       rc;
    logic       rs;
    int         total;
    int         ci_m;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Truth table indexed by {b, a, cin}
    vecs[0] = '{a:1'b0, b:1'b0, cin:1'b0, expected:2'b00};
    vecs[1] = '{a:1'b0, b:1'b0, cin:1'b1, expected:2'b01};
    vecs[2] = '{a:1'b1, b:1'b0, cin:1'b0, expected:2'b01};
    vecs[3] = '{a:1'b1, b:1'b0, cin:1'b1, expected:2'b10};
    vecs[4] = '{a:1'b0, b:1'b1, cin:1'b0, expected:2'b01};
    vecs[5] = '{a:1'b0, b:1'b1, cin:1'b1, expected:2'b10};
    vecs[6] = '{a:1'b1, b:1'b1, cin:1'b0, expected:2'b10};
    vecs[7] = '{a:1'b1, b:1'b1, cin:1'b1, expected:2'b11};

    // Reset state
    #3;
    check_output("reset_sum_q", int'(bus.sum_q), 0);
    check_output("reset_cout_q", int'(bus.cout_q), 0);
    check_output("reset_carry_state", int'(bus.carry_state), 0);

    // Exhaustive combinational table (outputs valid during reset too)
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      #1;
      check_output($sformatf("table_%0d", i), int'({bus.cout, bus.sum}), int'(vecs[i].expected));
    end

    // Registered latency: reset value before the edge, new value after
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("latency_pre_sum_q", int'(bus.sum_q), 0);
    check_output("latency_pre_cout_q", int'(bus.cout_q), 0);
    tick();
    check_output("latency_sum_q", int'(bus.sum_q), 0);
    check_output("latency_cout_q", int'(bus.cout_q), 1);

    // Serial add 3 + 3, LSB first
    @(negedge clk);
    pulse_reset();
    begin
      logic [2:0] sa;
      logic [2:0] sb;
      logic [2:0] exp_s;
      logic [2:0] exp_c;
      sa = 3'b011; sb = 3'b011; exp_s = 3'b110; exp_c = 3'b011;
      for (int i = 0; i < 3; i++) begin
        apply_stimulus(sa[i], sb[i], 1'b0, 1'b1);
        tick();
        check_output($sformatf("ser3_sum_q_%0d", i), int'(bus.sum_q), int'(exp_s[i]));
        check_output($sformatf("ser3_carry_%0d", i), int'(bus.carry_state), int'(exp_c[i]));
        @(negedge clk);
      end
    end

    // Serial overflow 1 + 1
    pulse_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("ovf_sum_q", int'(bus.sum_q), 0);
    check_output("ovf_carry", int'(bus.carry_state), 1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_output("ovf_comb_sum", int'(bus.sum), 1);

    // Asynchronous reset mid-operation: no edge needed
    #1;
    reset = 1'b1;
    #1;
    check_output("async_carry", int'(bus.carry_state), 0);
    check_output("async_sum_q", int'(bus.sum_q), 0);
    check_output("async_cout_q", int'(bus.cout_q), 0);
    check_output("async_comb_sum", int'(bus.sum), 0);
    @(negedge clk);
    reset = 1'b0;

    // Mode switch out of serial mode with a pending carry
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("mode_carry_set", int'(bus.carry_state), 1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("mode_comb_sum", int'(bus.sum), 0);
    tick();
    check_output("mode_carry_cleared", int'(bus.carry_state), 0);

    // Random single-cycle stimulus against the arithmetic reference
    m_carry  = 0;
    m_sum_q  = int'(bus.sum_q);
    m_cout_q = int'(bus.cout_q);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      apply_stimulus(ra, rb, rc, rs);
      ci_m  = rs ? m_carry : int'(rc);
      total = int'(ra) + int'(rb) + ci_m;
      #1;
      check_output("rand_comb", int'({bus.cout, bus.sum}), total);
      tick();
      m_sum_q  = total % 2;
      m_cout_q = total / 2;
      m_carry  = rs ? total / 2 : 0;
      check_output("rand_sum_q", int'(bus.sum_q), m_sum_q);
      check_output("rand_cout_q", int'(bus.cout_q), m_cout_q);
      check_output("rand_carry", int'(bus.carry_state), m_carry);
    end

    // Random 8-bit serial adds, carry cleared by one non-serial cycle
    for (int n = 0; n < 20; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        apply_stimulus(x[i], y[i], 1'($urandom_range(0, 1)), 1'b1);
        tick();
        res[i] = bus.sum_q;
      end
      check_output($sformatf("serial8_%0d", n), int'({bus.carry_state, res}), int'(x) + int'(y));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
